// File: rtl/ped_request_pkg.sv
// Shared types for the pedestrian request handler: FSM state encoding,
// timer width and press-counter saturation value.
package ped_request_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PENDING  = 3'd1,
    ST_GRANTED  = 3'd2,
    ST_WALK     = 3'd3,
    ST_COOLDOWN = 3'd4
  } ped_state_e;

  // Sized for the default cooldown; the blink period is always shorter.
  localparam int unsigned DEFAULT_COOLDOWN_TIME = 250000000;
  localparam int unsigned TIMER_W = $clog2(DEFAULT_COOLDOWN_TIME);
  typedef logic [TIMER_W-1:0] timer_t;

  localparam int unsigned DEFAULT_COUNT_W = 8;
  localparam int unsigned COUNT_MAX = (1 << DEFAULT_COUNT_W) - 1;

endpackage

// File: rtl/ped_request_handler_timer.sv
// Free-running interval counter: done pulses on the cycle the count equals
// terminal while enabled; the count then restarts from zero.
module ped_interval_timer
  import ped_request_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   enable,
  input  timer_t terminal,
  output logic   done
);

  timer_t count_reg;

  assign done = enable && (count_reg == terminal);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= done ? '0 : count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ped_request_handler.sv
// Pedestrian request latch with grant handshake, WAIT lamp and post-walk cooldown.
// Optional blinking WAIT lamp enabled by defining REQUEST_BLINK_EN.
module ped_request_handler
  import ped_request_pkg::*;
#(
  parameter int unsigned COOLDOWN_TIME     = 250000000,
  parameter int unsigned BLINK_HALF_PERIOD = 12500000,
  parameter int unsigned COUNT_W           = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               button_pressed,
  input  logic               ped_grant,
  input  logic               walk_active,
  output logic               ped_request,
  output logic               wait_lamp,
  output logic [COUNT_W-1:0] press_count,
  output logic [2:0]         state_dbg
);

  if (COOLDOWN_TIME < 2 || BLINK_HALF_PERIOD < 1) begin : g_param_check
    $error("ped_request_handler: COOLDOWN_TIME must be >= 2 and BLINK_HALF_PERIOD >= 1");
  end

  ped_state_e         state_reg, state_next;
  logic               deferred_reg, deferred_next;
  logic               count_inc;
  logic [COUNT_W-1:0] press_count_reg;
  logic               ped_request_reg;
  logic               wait_lamp_reg, wait_lamp_next;
  logic               cool_done;
  logic               lamp_on_next;

  ped_interval_timer u_cooldown_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_reg != ST_COOLDOWN),
    .enable   (state_reg == ST_COOLDOWN),
    .terminal (timer_t'(COOLDOWN_TIME - 1)),
    .done     (cool_done)
  );

  always_comb begin
    state_next    = state_reg;
    deferred_next = deferred_reg;
    count_inc     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (walk_active) begin
          state_next = ST_WALK;
        end else if (button_pressed) begin
          state_next = ST_PENDING;
          count_inc  = 1'b1;
        end
      end
      ST_PENDING: begin
        if (walk_active) state_next = ST_WALK;
        else if (ped_grant) state_next = ST_GRANTED;
      end
      ST_GRANTED: begin
        if (walk_active) state_next = ST_WALK;
      end
      ST_WALK: begin
        if (!walk_active) state_next = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        // A new walk phase serves any deferred request.
        if (walk_active) begin
          state_next    = ST_WALK;
          deferred_next = 1'b0;
        end else begin
          if (button_pressed) begin
            deferred_next = 1'b1;
            count_inc     = !deferred_reg;
          end
          if (cool_done) begin
            state_next    = deferred_next ? ST_PENDING : ST_IDLE;
            deferred_next = 1'b0;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign lamp_on_next = (state_next == ST_PENDING) || (state_next == ST_GRANTED);

`ifdef REQUEST_BLINK_EN
  logic in_service;
  logic blink_done;

  assign in_service = (state_reg == ST_PENDING) || (state_reg == ST_GRANTED);

  // Phase runs across PENDING->GRANTED; it restarts only on a fresh entry.
  ped_interval_timer u_blink_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!in_service),
    .enable   (in_service),
    .terminal (timer_t'(BLINK_HALF_PERIOD - 1)),
    .done     (blink_done)
  );

  always_comb begin
    wait_lamp_next = 1'b0;
    if (lamp_on_next) begin
      wait_lamp_next = in_service ? (wait_lamp_reg ^ blink_done) : 1'b1;
    end
  end
`else
  assign wait_lamp_next = lamp_on_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      deferred_reg    <= 1'b0;
      press_count_reg <= '0;
      ped_request_reg <= 1'b0;
      wait_lamp_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      deferred_reg    <= deferred_next;
      ped_request_reg <= (state_next == ST_PENDING);
      wait_lamp_reg   <= wait_lamp_next;
      if (count_inc && (press_count_reg != {COUNT_W{1'b1}})) begin
        press_count_reg <= press_count_reg + 1'b1;
      end
    end
  end

  assign ped_request = ped_request_reg;
  assign wait_lamp   = wait_lamp_reg;
  assign press_count = press_count_reg;
  assign state_dbg   = state_reg;

endmodule

// File: tb/tb_ped_request_handler.sv
// Directed self-checking bench for ped_request_handler (COOLDOWN_TIME=8,
// BLINK_HALF_PERIOD=4); honours REQUEST_BLINK_EN for the lamp pattern.
module tb_ped_request_handler;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PEND = 3'd1;
  localparam logic [2:0] S_GRNT = 3'd2;
  localparam logic [2:0] S_WALK = 3'd3;
  localparam logic [2:0] S_COOL = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       button_pressed;
  logic       ped_grant;
  logic       walk_active;
  logic       ped_request;
  logic       wait_lamp;
  logic [7:0] press_count;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  ped_request_handler #(
    .COOLDOWN_TIME     (8),
    .BLINK_HALF_PERIOD (4),
    .COUNT_W           (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .button_pressed (button_pressed),
    .ped_grant      (ped_grant),
    .walk_active    (walk_active),
    .ped_request    (ped_request),
    .wait_lamp      (wait_lamp),
    .press_count    (press_count),
    .state_dbg      (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [2:0] st, input logic req,
                     input logic lamp, input logic [7:0] cnt);
    checks++;
    if (state_dbg !== st || ped_request !== req || wait_lamp !== lamp || press_count !== cnt) begin
      failures++;
      $display("FAIL %s: got state=%0d req=%b lamp=%b count=%0d, want state=%0d req=%b lamp=%b count=%0d",
               name, state_dbg, ped_request, wait_lamp, press_count, st, req, lamp, cnt);
    end else begin
      $display("ok   %s: state=%0d req=%b lamp=%b count=%0d", name, state_dbg, ped_request, wait_lamp, press_count);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; button_pressed = 1'b0; ped_grant = 1'b0; walk_active = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("reset", S_IDLE, 1'b0, 1'b0, 8'd0);
    ped_grant = 1'b1; tick(1); ped_grant = 1'b0;
    chk("stray_grant_idle", S_IDLE, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic test_press;
    button_pressed = 1'b1; tick(1); button_pressed = 1'b0;
    chk("press_to_pending", S_PEND, 1'b1, 1'b1, 8'd1);
    button_pressed = 1'b1; tick(1); button_pressed = 1'b0;
    chk("press_ignored_pending", S_PEND, 1'b1, 1'b1, 8'd1);
  endtask

  task automatic test_grant_walk;
    ped_grant = 1'b1; tick(1); ped_grant = 1'b0;
    chk("grant", S_GRNT, 1'b0, 1'b1, 8'd1);
    button_pressed = 1'b1; tick(1); button_pressed = 1'b0;
    chk("press_ignored_granted", S_GRNT, 1'b0, 1'b1, 8'd1);
    walk_active = 1'b1; tick(1);
    chk("walk", S_WALK, 1'b0, 1'b0, 8'd1);
    button_pressed = 1'b1; tick(1); button_pressed = 1'b0;
    chk("press_ignored_walk", S_WALK, 1'b0, 1'b0, 8'd1);
  endtask

  task automatic test_cooldown_deferred;
    walk_active = 1'b0; tick(1);
    chk("cooldown_entry", S_COOL, 1'b0, 1'b0, 8'd1);
    button_pressed = 1'b1; tick(1);
    chk("deferred_press", S_COOL, 1'b0, 1'b0, 8'd2);
    tick(2); button_pressed = 1'b0;
    chk("repeat_press_not_counted", S_COOL, 1'b0, 1'b0, 8'd2);
    tick(4);
    chk("cooldown_last_cycle", S_COOL, 1'b0, 1'b0, 8'd2);
    tick(1);
    chk("deferred_to_pending", S_PEND, 1'b1, 1'b1, 8'd2);
  endtask

  task automatic test_blink;
    logic exp_lamp;
    for (int i = 0; i < 12; i++) begin
`ifdef REQUEST_BLINK_EN
      exp_lamp = ((i / 4) % 2) == 0;
`else
      exp_lamp = 1'b1;
`endif
      chk($sformatf("lamp_cycle_%0d", i), (i <= 2) ? S_PEND : S_GRNT, i <= 2, exp_lamp, 8'd2);
      if (i == 2) ped_grant = 1'b1;
      tick(1);
      ped_grant = 1'b0;
    end
    walk_active = 1'b1; tick(1);
    walk_active = 1'b0; tick(1);
    tick(8);
    chk("cooldown_to_idle", S_IDLE, 1'b0, 1'b0, 8'd2);
  endtask

  task automatic test_simultaneous;
    button_pressed = 1'b1; walk_active = 1'b1; tick(1); button_pressed = 1'b0;
    chk("idle_press_and_walk", S_WALK, 1'b0, 1'b0, 8'd2);
    walk_active = 1'b0; tick(1);
    button_pressed = 1'b1; tick(1); button_pressed = 1'b0;
    chk("cooldown_press", S_COOL, 1'b0, 1'b0, 8'd3);
    walk_active = 1'b1; tick(1);
    chk("walk_during_cooldown", S_WALK, 1'b0, 1'b0, 8'd3);
    walk_active = 1'b0; tick(9);
    chk("served_deferred_to_idle", S_IDLE, 1'b0, 1'b0, 8'd3);
    button_pressed = 1'b1; tick(1); button_pressed = 1'b0;
    ped_grant = 1'b1; walk_active = 1'b1; tick(1); ped_grant = 1'b0;
    chk("pending_grant_and_walk", S_WALK, 1'b0, 1'b0, 8'd4);
    walk_active = 1'b0; tick(9);
    chk("back_to_idle", S_IDLE, 1'b0, 1'b0, 8'd4);
  endtask

  task automatic test_saturation;
    int exp_cnt;
    for (int k = 1; k <= 300; k++) begin
      button_pressed = 1'b1; tick(1); button_pressed = 1'b0;
      walk_active = 1'b1; tick(1);
      walk_active = 1'b0; tick(9);
      exp_cnt = (4 + k > 255) ? 255 : 4 + k;
      checks++;
      if (press_count !== exp_cnt[7:0] || state_dbg !== S_IDLE) begin
        failures++;
        $display("FAIL saturation_iter_%0d: got count=%0d state=%0d, want count=%0d state=0",
                 k, press_count, state_dbg, exp_cnt);
      end
    end
    $display("saturation loop done: count=%0d", press_count);
  endtask

  task automatic test_reset_mid;
    button_pressed = 1'b1; tick(1); button_pressed = 1'b0;
    chk("pending_at_saturation", S_PEND, 1'b1, 1'b1, 8'd255);
    rst = 1'b1; button_pressed = 1'b1; tick(1); rst = 1'b0; button_pressed = 1'b0;
    chk("reset_mid_pending", S_IDLE, 1'b0, 1'b0, 8'd0);
    button_pressed = 1'b1; tick(1); button_pressed = 1'b0;
    chk("press_after_reset", S_PEND, 1'b1, 1'b1, 8'd1);
  endtask

  initial begin
    test_reset();
    test_press();
    test_grant_walk();
    test_cooldown_deferred();
    test_blink();
    test_simultaneous();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
